// File: rtl/stream_dma_writer_if.sv
// Avalon-MM style SDRAM write bus between stream_dma_writer (master) and the
// SDRAM controller port (slave).
interface stream_dma_writer_if #(
  parameter int MEM_W  = 128,
  parameter int ADDR_W = 28
);
  logic [MEM_W-1:0]  writedata;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic              waitrequest;

  modport master (output writedata, address, write, input waitrequest);
  modport slave  (input writedata, address, write, output waitrequest);
endinterface

// File: rtl/stream_dma_writer.sv
// Streaming DMA write path: packs IN_W words into MEM_W words, queues buffer
// descriptors and drains them to the SDRAM bus. DMA_OVERFLOW_CNT_EN adds ovf_cnt.
module stream_dma_writer #(
  parameter int IN_W         = 32,
  parameter int MEM_W        = 128,
  parameter int ADDR_W       = 28,
  parameter int DEPTH        = 1024,
  parameter int CMD_DEPTH    = 8,
  parameter int AFULL_MARGIN = 16,
  parameter int ADDR_STEP    = 1
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [IN_W-1:0]   din,
  input  logic              din_dv,
  output logic              afull,
  input  logic [ADDR_W-1:0] start_adr,
  input  logic [ADDR_W-1:0] buf_size,
  input  logic              start,
  output logic [15:0]       done_cnt,
  output logic              cmd_fifo_empty,
  output logic              cmd_fifo_aempty,
  stream_dma_writer_if.master sdram
`ifdef DMA_OVERFLOW_CNT_EN
  , output logic [15:0]     ovf_cnt
`endif
);
  localparam int RATIO = MEM_W / IN_W;
  localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int UW    = AW + 1;
  localparam int CW    = $clog2(CMD_DEPTH);
  localparam int CUW   = CW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remain;
  logic              write_q;

  // packer
  logic [PW-1:0]    pack_cnt;
  logic [MEM_W-1:0] pack_buf;
  logic [MEM_W-1:0] pack_word;
  logic             pack_push;

  always_comb begin
    pack_word = pack_buf;
    pack_word[pack_cnt*IN_W +: IN_W] = din;
    pack_push = din_dv && (pack_cnt == PW'(RATIO - 1));
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pack_cnt <= '0;
      pack_buf <= '0;
    end else if (din_dv) begin
      pack_buf <= pack_word;
      pack_cnt <= pack_push ? '0 : pack_cnt + PW'(1);
    end
  end

  // data FIFO, show-ahead
  logic [MEM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [UW-1:0]    used, used_next, used_after_pop;
  logic             push_ok, pop;

  always_comb begin
    push_ok        = pack_push && (used != UW'(DEPTH));
    pop            = write_q && !sdram.waitrequest;
    used_after_pop = used - UW'(pop);
    used_next      = used_after_pop + UW'(push_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= pack_word;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      afull  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      used  <= used_next;
      afull <= (UW'(DEPTH) - used_next) <= UW'(AFULL_MARGIN);
    end
  end

  // descriptor FIFO, show-ahead; pops only in LOAD
  logic [2*ADDR_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CW-1:0]       cmd_wr, cmd_rd;
  logic [CUW-1:0]      cmd_cnt, cmd_cnt_next;
  logic                cmd_push, cmd_pop;
  logic [ADDR_W-1:0]   head_adr, head_size;

  always_comb begin
    cmd_push     = start && (cmd_cnt != CUW'(CMD_DEPTH));
    cmd_pop      = (state == LOAD);
    cmd_cnt_next = cmd_cnt + CUW'(cmd_push) - CUW'(cmd_pop);
    {head_adr, head_size} = cmd_mem[cmd_rd];
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr] <= {start_adr, buf_size};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cmd_wr          <= '0;
      cmd_rd          <= '0;
      cmd_cnt         <= '0;
      cmd_fifo_empty  <= 1'b1;
      cmd_fifo_aempty <= 1'b1;
    end else begin
      if (cmd_push) cmd_wr <= cmd_wr + CW'(1);
      if (cmd_pop)  cmd_rd <= cmd_rd + CW'(1);
      cmd_cnt         <= cmd_cnt_next;
      cmd_fifo_empty  <= (cmd_cnt_next == '0);
      cmd_fifo_aempty <= (cmd_cnt_next <= CUW'(1));
    end
  end

  // write FSM; write_q is decided from the pre-push count, so a freshly
  // pushed word shows on the bus two cycles after its last input beat
  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= IDLE;
      addr     <= '0;
      remain   <= '0;
      write_q  <= 1'b0;
      done_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (!cmd_fifo_empty) state <= LOAD;
        LOAD: begin
          addr   <= head_adr;
          remain <= head_size;
          if (head_size == '0) begin
            state <= DONE;
          end else begin
            state   <= WRITE;
            write_q <= (used != '0);
          end
        end
        WRITE: begin
          if (pop) begin
            addr   <= addr + ADDR_W'(ADDR_STEP);
            remain <= remain - ADDR_W'(1);
          end
          if (pop && remain == ADDR_W'(1)) begin
            state   <= DONE;
            write_q <= 1'b0;
          end else begin
            write_q <= (used_after_pop != '0);
          end
        end
        DONE: begin
          done_cnt <= done_cnt + 16'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sdram.write     = write_q;
  assign sdram.address   = addr;
  assign sdram.writedata = write_q ? mem[rd_ptr] : '0;

`ifdef DMA_OVERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (srst) ovf_cnt <= '0;
    else if (pack_push && !push_ok && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_stream_dma_writer.sv
// Directed bench for stream_dma_writer with RATIO=4, DEPTH=16, AFULL_MARGIN=4.
module tb_stream_dma_writer;
  logic         clk = 1'b0;
  logic         srst = 1'b0;
  logic [31:0]  din = '0;
  logic         din_dv = 1'b0;
  logic         afull;
  logic [27:0]  start_adr = '0;
  logic [27:0]  buf_size = '0;
  logic         start = 1'b0;
  logic [15:0]  done_cnt;
  logic         cmd_fifo_empty, cmd_fifo_aempty;
`ifdef DMA_OVERFLOW_CNT_EN
  logic [15:0]  ovf_cnt;
`endif

  stream_dma_writer_if #(.MEM_W(128), .ADDR_W(28)) bus ();

  stream_dma_writer #(
    .IN_W(32), .MEM_W(128), .ADDR_W(28), .DEPTH(16),
    .CMD_DEPTH(8), .AFULL_MARGIN(4), .ADDR_STEP(1)
  ) dut (
    .clk(clk), .srst(srst), .din(din), .din_dv(din_dv), .afull(afull),
    .start_adr(start_adr), .buf_size(buf_size), .start(start),
    .done_cnt(done_cnt), .cmd_fifo_empty(cmd_fifo_empty),
    .cmd_fifo_aempty(cmd_fifo_aempty), .sdram(bus)
`ifdef DMA_OVERFLOW_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] wr_data_q[$];
  logic [27:0]  wr_addr_q[$];

  always @(negedge clk) begin
    if (!srst && bus.write && !bus.waitrequest) begin
      wr_data_q.push_back(bus.writedata);
      wr_addr_q.push_back(bus.address);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pk(input int b);
    return {32'(b + 3), 32'(b + 2), 32'(b + 1), 32'(b)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    srst = 1'b1; din_dv = 1'b0; start = 1'b0;
    tick;
    srst = 1'b0;
    wr_data_q.delete();
    wr_addr_q.delete();
  endtask

  task automatic push_desc(input logic [27:0] adr, input logic [27:0] size);
    start_adr = adr; buf_size = size; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      din = 32'(base + i); din_dv = 1'b1;
      tick;
    end
    din_dv = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt != 16'(target); i++) tick;
    chk(tag, 128'(done_cnt), 128'(target));
  endtask

  initial begin
    bus.waitrequest = 1'b0;
    do_reset;
    chk("rst_write", 128'(bus.write), 128'd0);
    chk("rst_addr", 128'(bus.address), 128'd0);
    chk("rst_data", bus.writedata, 128'd0);
    chk("rst_afull", 128'(afull), 128'd0);
    chk("rst_done", 128'(done_cnt), 128'd0);
    chk("rst_empty", 128'(cmd_fifo_empty), 128'd1);
    chk("rst_aempty", 128'(cmd_fifo_aempty), 128'd1);

    // basic two-word buffer
    push_desc(28'h100, 28'd2);
    send_words(0, 8);
    wait_done("t1_done", 1, 60);
    chk("t1_n", 128'(wr_addr_q.size()), 128'd2);
    chk("t1_a0", 128'(wr_addr_q[0]), 128'h100);
    chk("t1_d0", wr_data_q[0], 128'h00000003_00000002_00000001_00000000);
    chk("t1_a1", 128'(wr_addr_q[1]), 128'h101);
    chk("t1_d1", wr_data_q[1], 128'h00000007_00000006_00000005_00000004);
    chk("t1_empty", 128'(cmd_fifo_empty), 128'd1);

    // stall the first write for three cycles
    do_reset;
    bus.waitrequest = 1'b1;
    push_desc(28'h100, 28'd2);
    send_words(0, 4);
    for (int i = 0; i < 20 && !bus.write; i++) tick;
    chk("t2_rise", 128'(bus.write), 128'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t2_hold_w", 128'(bus.write), 128'd1);
      chk("t2_hold_a", 128'(bus.address), 128'h100);
      chk("t2_hold_d", bus.writedata, pk(0));
    end
    bus.waitrequest = 1'b0;
    send_words(4, 4);
    wait_done("t2_done", 1, 60);
    chk("t2_n", 128'(wr_addr_q.size()), 128'd2);
    chk("t2_a1", 128'(wr_addr_q[1]), 128'h101);
    chk("t2_d1", wr_data_q[1], pk(4));

    // address wrap and zero-size descriptor
    do_reset;
    push_desc(28'hFFFFFFF, 28'd2);
    push_desc(28'h200, 28'd0);
    send_words(16, 8);
    wait_done("t3_done", 2, 80);
    chk("t3_n", 128'(wr_addr_q.size()), 128'd2);
    chk("t3_a0", 128'(wr_addr_q[0]), 128'hFFFFFFF);
    chk("t3_a1", 128'(wr_addr_q[1]), 128'h0);
    chk("t3_d1", wr_data_q[1], pk(20));

    // AFULL threshold and full FIFO with no descriptor
    do_reset;
    send_words(0, 44);
    chk("t4_afull11", 128'(afull), 128'd0);
    send_words(44, 4);
    chk("t4_afull12", 128'(afull), 128'd1);
    send_words(48, 16);
    tick; tick;
    chk("t4_nowr", 128'(wr_addr_q.size()), 128'd0);
`ifdef DMA_OVERFLOW_CNT_EN
    chk("t4_ovf", 128'(ovf_cnt), 128'd0);
`endif
    push_desc(28'h0, 28'd16);
    wait_done("t4_done", 1, 80);
    chk("t4_n", 128'(wr_addr_q.size()), 128'd16);
    chk("t4_d0", wr_data_q[0], pk(0));
    chk("t4_d15", wr_data_q[15], pk(60));
    chk("t4_afull_drained", 128'(afull), 128'd0);

    // overflow: two packed words dropped
    do_reset;
    send_words(0, 72);
`ifdef DMA_OVERFLOW_CNT_EN
    chk("t5_ovf", 128'(ovf_cnt), 128'd2);
`endif
    push_desc(28'h0, 28'd16);
    wait_done("t5_done", 1, 80);
    chk("t5_n", 128'(wr_addr_q.size()), 128'd16);
    chk("t5_d15", wr_data_q[15], pk(60));

    // descriptor FIFO full while the FSM waits for data
    do_reset;
    push_desc(28'h300, 28'd1);
    tick; tick; tick; tick;
    for (int i = 0; i < 9; i++) push_desc(28'(32'h400 + i), 28'd1);
    tick;
    chk("t6_empty", 128'(cmd_fifo_empty), 128'd0);
    chk("t6_aempty", 128'(cmd_fifo_aempty), 128'd0);
    for (int k = 1; k <= 9; k++) begin
      send_words(32'h1000 + 4 * k, 4);
      wait_done("t6_done_k", k, 40);
      tick; tick; tick; tick;
      chk("t6_aempty_k", 128'(cmd_fifo_aempty), 128'((8 - k) <= 1));
      chk("t6_empty_k", 128'(cmd_fifo_empty), 128'((8 - k) <= 0));
    end
    send_words(32'h2000, 4);
    for (int i = 0; i < 30; i++) tick;
    chk("t6_done_final", 128'(done_cnt), 128'd9);
    chk("t6_n", 128'(wr_addr_q.size()), 128'd9);
    chk("t6_a0", 128'(wr_addr_q[0]), 128'h300);
    chk("t6_alast", 128'(wr_addr_q[wr_addr_q.size() - 1]), 128'h407);

    // reset in the middle of a stalled write
    do_reset;
    push_desc(28'h500, 28'd8);
    send_words(32'h20, 12);
    for (int i = 0; i < 40 && wr_addr_q.size() < 3; i++) tick;
    chk("t7_pre_n", 128'(wr_addr_q.size()), 128'd3);
    bus.waitrequest = 1'b1;
    send_words(32'h2C, 4);
    tick; tick;
    chk("t7_mid_w", 128'(bus.write), 128'd1);
    chk("t7_mid_a", 128'(bus.address), 128'h503);
    srst = 1'b1;
    tick;
    chk("t7_rst_w", 128'(bus.write), 128'd0);
    chk("t7_rst_a", 128'(bus.address), 128'd0);
    chk("t7_rst_d", bus.writedata, 128'd0);
    chk("t7_rst_done", 128'(done_cnt), 128'd0);
    chk("t7_rst_empty", 128'(cmd_fifo_empty), 128'd1);
    chk("t7_rst_aempty", 128'(cmd_fifo_aempty), 128'd1);
    chk("t7_rst_afull", 128'(afull), 128'd0);
    srst = 1'b0;
    bus.waitrequest = 1'b0;
    wr_data_q.delete();
    wr_addr_q.delete();
    push_desc(28'h600, 28'd1);
    send_words(32'hA0, 4);
    wait_done("t7_done", 1, 40);
    chk("t7_n", 128'(wr_addr_q.size()), 128'd1);
    chk("t7_a", 128'(wr_addr_q[0]), 128'h600);
    chk("t7_d", wr_data_q[0], pk(32'hA0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
